// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM.
// Sequences each instruction through FETCH, DECODE and the execute/memory/
// writeback states. It drives the per-state datapath enables and stalls on
// mem_ready during instruction fetch, load and store.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   op, funct          IR[31:26] and IR[5:0]; only sampled in DECODE
//   mem_ready          memory access completes this cycle
//   pc_write .. jal    single-bit datapath controls
//   alu_src_b          00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   pc_source          00 ALU, 01 ALUOut, 10 jump target, 11 register rs
//   alu_op             ALU operation code (opcode zero-extended)
//   instr_done         one-cycle retire pulse
//   illegal_op         sticky illegal-opcode flag
//   state              current state, for debug
module multicycle_control #(
  parameter int unsigned         ALUOP_W         = 6,
  parameter logic [ALUOP_W-1:0]  ALU_ADD_CODE    = ALUOP_W'(6'h08),
  parameter bit                  TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               branch_ne,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic               jal,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_source,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    I_EXEC   = 4'd10,
    I_WB     = 4'd11,
    JAL_WB   = 4'd12,
    TRAP     = 4'd13
  } stateT;

  stateT      stateQ, stateNext;
  logic [5:0] opQ;
  logic       rjrQ;
  logic       illegalQ;
  logic       setIllegal;

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= FETCH;
      opQ      <= '0;
      rjrQ     <= 1'b0;
      illegalQ <= 1'b0;
    end else begin
      stateQ <= stateNext;
      if (stateQ == DECODE) begin
        opQ  <= op;
        rjrQ <= (op == 6'h00) && (funct == 6'h08);
      end
      if (setIllegal) begin
        illegalQ <= 1'b1;
      end
    end
  end

  always_comb begin
    stateNext     = stateQ;
    setIllegal    = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    jal           = 1'b0;
    alu_src_b     = 2'b00;
    pc_source     = 2'b00;
    alu_op        = '0;
    instr_done    = 1'b0;

    case (stateQ)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD_CODE;
        // IR load and PC+4 only commit on the cycle the fetch completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          stateNext = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD_CODE;
        case (op)
          6'h00:                      stateNext = (funct == 6'h08) ? JUMP : R_EXEC;
          6'h08, 6'h0c, 6'h0d, 6'h0f: stateNext = I_EXEC;
          6'h23, 6'h2b:               stateNext = MEM_ADDR;
          6'h04, 6'h05:               stateNext = BRANCH;
          6'h02:                      stateNext = JUMP;
          6'h03:                      stateNext = JAL_WB;
          default: begin
            setIllegal = 1'b1;
            if (TRAP_ON_ILLEGAL) begin
              stateNext = TRAP;
            end else begin
              // Treated as a NOP: retire straight from DECODE.
              stateNext  = FETCH;
              instr_done = 1'b1;
            end
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALUOP_W'(opQ);
        stateNext = (opQ == 6'h23) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          stateNext = MEM_WB;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          stateNext  = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        stateNext = R_WB;
      end
      R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALUOP_W'(opQ);
        stateNext = I_WB;
      end
      I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_W'(opQ);
        pc_write_cond = 1'b1;
        branch_ne     = (opQ == 6'h05);
        pc_source     = 2'b01;
        instr_done    = 1'b1;
        stateNext     = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = rjrQ ? 2'b11 : 2'b10;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      JAL_WB: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        reg_write  = 1'b1;
        jal        = 1'b1;
        instr_done = 1'b1;
        stateNext  = FETCH;
      end
      TRAP: begin
        stateNext = TRAP;
      end
      default: begin
        stateNext = FETCH;
      end
    endcase
  end

  assign illegal_op = illegalQ;
  assign state      = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (trapping and non-trapping)
// share the stimulus. Expected state paths, outputs and latencies come from
// an instruction-level model.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rstA, rstB, memReady;
  logic [5:0] op, funct;

  always #5 clk = ~clk;

  logic       pcWriteA, pcWriteCondA, branchNeA, iOrDA, memReadA, memWriteA, irWriteA;
  logic       memToRegA, regDstA, regWriteA, aluSrcAA, jalA, instrDoneA, illegalA;
  logic [1:0] aluSrcBA, pcSourceA;
  logic [5:0] aluOpA;
  logic [3:0] stateA;
  logic       pcWriteB, pcWriteCondB, branchNeB, iOrDB, memReadB, memWriteB, irWriteB;
  logic       memToRegB, regDstB, regWriteB, aluSrcAB, jalB, instrDoneB, illegalB;
  logic [1:0] aluSrcBB, pcSourceB;
  logic [5:0] aluOpB;
  logic [3:0] stateB;

  multicycle_control #(.ALUOP_W(6), .ALU_ADD_CODE(6'h08), .TRAP_ON_ILLEGAL(1'b1)) dutA (
    .clk(clk), .reset(rstA), .op(op), .funct(funct), .mem_ready(memReady),
    .pc_write(pcWriteA), .pc_write_cond(pcWriteCondA), .branch_ne(branchNeA),
    .i_or_d(iOrDA), .mem_read(memReadA), .mem_write(memWriteA), .ir_write(irWriteA),
    .mem_to_reg(memToRegA), .reg_dst(regDstA), .reg_write(regWriteA),
    .alu_src_a(aluSrcAA), .jal(jalA), .alu_src_b(aluSrcBA), .pc_source(pcSourceA),
    .alu_op(aluOpA), .instr_done(instrDoneA), .illegal_op(illegalA), .state(stateA)
  );

  multicycle_control #(.ALUOP_W(6), .ALU_ADD_CODE(6'h08), .TRAP_ON_ILLEGAL(1'b0)) dutB (
    .clk(clk), .reset(rstB), .op(op), .funct(funct), .mem_ready(memReady),
    .pc_write(pcWriteB), .pc_write_cond(pcWriteCondB), .branch_ne(branchNeB),
    .i_or_d(iOrDB), .mem_read(memReadB), .mem_write(memWriteB), .ir_write(irWriteB),
    .mem_to_reg(memToRegB), .reg_dst(regDstB), .reg_write(regWriteB),
    .alu_src_a(aluSrcAB), .jal(jalB), .alu_src_b(aluSrcBB), .pc_source(pcSourceB),
    .alu_op(aluOpB), .instr_done(instrDoneB), .illegal_op(illegalB), .state(stateB)
  );

  logic [22:0] vecA, vecB;
  assign vecA = {pcWriteA, pcWriteCondA, branchNeA, iOrDA, memReadA, memWriteA, irWriteA,
                 memToRegA, regDstA, regWriteA, aluSrcAA, jalA, aluSrcBA, pcSourceA,
                 aluOpA, instrDoneA};
  assign vecB = {pcWriteB, pcWriteCondB, branchNeB, iOrDB, memReadB, memWriteB, irWriteB,
                 memToRegB, regDstB, regWriteB, aluSrcAB, jalB, aluSrcBB, pcSourceB,
                 aluOpB, instrDoneB};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Control outputs the datapath needs in each step of an instruction.
  function automatic logic [22:0] expOuts(input logic [3:0] st, input logic mr,
                                          input logic [5:0] opq, input logic rjr,
                                          input logic decDone);
    logic pw, pwc, bne, iod, rd, wr, irw, m2r, rdst, rw, asa, jl, dn;
    logic [1:0] asb, pcs;
    logic [5:0] aop;
    {pw, pwc, bne, iod, rd, wr, irw, m2r, rdst, rw, asa, jl, dn} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 6'h00;
    case (st)
      4'd0:  begin rd = 1; asb = 2'b01; aop = 6'h08; irw = mr; pw = mr; end
      4'd1:  begin asb = 2'b11; aop = 6'h08; dn = decDone; end
      4'd2:  begin asa = 1; asb = 2'b10; aop = opq; end
      4'd3:  begin rd = 1; iod = 1; end
      4'd4:  begin rw = 1; m2r = 1; dn = 1; end
      4'd5:  begin wr = 1; iod = 1; dn = mr; end
      4'd6:  begin asa = 1; end
      4'd7:  begin rw = 1; rdst = 1; dn = 1; end
      4'd8:  begin asa = 1; aop = opq; pwc = 1; bne = (opq == 6'h05); pcs = 2'b01; dn = 1; end
      4'd9:  begin pw = 1; pcs = rjr ? 2'b11 : 2'b10; dn = 1; end
      4'd10: begin asa = 1; asb = 2'b10; aop = opq; end
      4'd11: begin rw = 1; dn = 1; end
      4'd12: begin pw = 1; pcs = 2'b10; rw = 1; jl = 1; dn = 1; end
      default: ;
    endcase
    return {pw, pwc, bne, iod, rd, wr, irw, m2r, rdst, rw, asa, jl, asb, pcs, aop, dn};
  endfunction

  // One clock cycle: drive at the falling edge, check 1 time unit later.
  task automatic stepChk(input logic [3:0] stA, input logic [3:0] stB, input logic mr,
                         input logic [5:0] dOp, input logic [5:0] dFn,
                         input logic [5:0] opq, input logic rjr,
                         input logic ddA, input logic ddB, input string tag);
    @(negedge clk);
    memReady = mr;
    op       = dOp;
    funct    = dFn;
    #1;
    chk({tag, "_stateA"}, 32'(stateA), 32'(stA));
    chk({tag, "_outsA"},  32'(vecA), 32'(expOuts(stA, mr, opq, rjr, ddA)));
    chk({tag, "_stateB"}, 32'(stateB), 32'(stB));
    chk({tag, "_outsB"},  32'(vecB), 32'(expOuts(stB, mr, opq, rjr, ddB)));
    chk({tag, "_rdwrExcl"}, 32'(memReadA & memWriteA), 32'd0);
  endtask

  // Runs one legal instruction on both instances with the given wait states.
  task automatic runInstr(input logic [5:0] iop, input logic [5:0] ifn,
                          input int unsigned fWait, input int unsigned mWait,
                          input string tag);
    logic [3:0] stQ[$];
    logic       mrQ[$];
    int         lat;
    int         doneCnt;
    int         doneAt;
    logic       rjr;
    logic [5:0] dOp;
    logic [5:0] dFn;
    rjr = (iop == 6'h00) && (ifn == 6'h08);
    for (int unsigned i = 0; i < fWait; i++) begin stQ.push_back(4'd0); mrQ.push_back(1'b0); end
    stQ.push_back(4'd0); mrQ.push_back(1'b1);
    stQ.push_back(4'd1); mrQ.push_back(1'($urandom));
    case (iop)
      6'h00: begin
        if (rjr) begin stQ.push_back(4'd9); mrQ.push_back(1'($urandom)); lat = 3; end
        else begin
          stQ.push_back(4'd6); mrQ.push_back(1'($urandom));
          stQ.push_back(4'd7); mrQ.push_back(1'($urandom));
          lat = 4;
        end
      end
      6'h08, 6'h0c, 6'h0d, 6'h0f: begin
        stQ.push_back(4'd10); mrQ.push_back(1'($urandom));
        stQ.push_back(4'd11); mrQ.push_back(1'($urandom));
        lat = 4;
      end
      6'h23: begin
        stQ.push_back(4'd2); mrQ.push_back(1'($urandom));
        for (int unsigned i = 0; i < mWait; i++) begin stQ.push_back(4'd3); mrQ.push_back(1'b0); end
        stQ.push_back(4'd3); mrQ.push_back(1'b1);
        stQ.push_back(4'd4); mrQ.push_back(1'($urandom));
        lat = 5 + int'(mWait);
      end
      6'h2b: begin
        stQ.push_back(4'd2); mrQ.push_back(1'($urandom));
        for (int unsigned i = 0; i < mWait; i++) begin stQ.push_back(4'd5); mrQ.push_back(1'b0); end
        stQ.push_back(4'd5); mrQ.push_back(1'b1);
        lat = 4 + int'(mWait);
      end
      6'h04, 6'h05: begin stQ.push_back(4'd8);  mrQ.push_back(1'($urandom)); lat = 3; end
      6'h02:        begin stQ.push_back(4'd9);  mrQ.push_back(1'($urandom)); lat = 3; end
      default:      begin stQ.push_back(4'd12); mrQ.push_back(1'($urandom)); lat = 3; end
    endcase
    lat = lat + int'(fWait);
    doneCnt = 0;
    doneAt  = 0;
    foreach (stQ[i]) begin
      // Opcode fields only matter up to DECODE; scramble them afterwards.
      dOp = (stQ[i] <= 4'd1) ? iop : 6'($urandom);
      dFn = (stQ[i] <= 4'd1) ? ifn : 6'($urandom);
      stepChk(stQ[i], stQ[i], mrQ[i], dOp, dFn, iop, rjr, 1'b0, 1'b0, tag);
      if (instrDoneA === 1'b1) begin
        doneCnt++;
        doneAt = i + 1;
      end
    end
    chk({tag, "_doneCount"}, 32'(doneCnt), 32'd1);
    chk({tag, "_latency"},   32'(doneAt), 32'(lat));
    chk({tag, "_illegalA"},  32'(illegalA), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] legalOps [11];
    logic [5:0] rop;
    logic [5:0] rfn;
    legalOps = '{6'h00, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03};

    rstA = 1'b1; rstB = 1'b1; memReady = 1'b0; op = 6'h00; funct = 6'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state",   32'(stateA), 32'd0);
    chk("reset_memRead", 32'(memReadA), 32'd1);
    chk("reset_irWrite", 32'(irWriteA), 32'd0);
    chk("reset_pcWrite", 32'(pcWriteA), 32'd0);
    chk("reset_illegal", 32'(illegalA), 32'd0);
    rstA = 1'b0; rstB = 1'b0;
    for (int i = 0; i < 5; i++) stepChk(4'd0, 4'd0, 1'b0, 6'h00, 6'h20, 6'h00, 1'b0, 1'b0, 1'b0, "stall");

    runInstr(6'h00, 6'h20, 0, 0, "add");
    runInstr(6'h23, 6'h00, 0, 3, "lw_wait3");
    runInstr(6'h05, 6'h00, 0, 0, "bne");
    runInstr(6'h04, 6'h00, 0, 0, "beq");
    runInstr(6'h03, 6'h00, 0, 0, "jal");
    runInstr(6'h00, 6'h08, 0, 0, "jr");
    runInstr(6'h02, 6'h00, 1, 0, "j_fwait");
    runInstr(6'h2b, 6'h00, 2, 2, "sw_wait");

    for (int n = 0; n < 40; n++) begin
      rop = legalOps[$urandom_range(10, 0)];
      rfn = ($urandom_range(3, 0) == 0) ? 6'h08 : 6'($urandom);
      runInstr(rop, rfn, $urandom_range(2, 0), $urandom_range(3, 0), "rand");
    end

    // Reset in the middle of a store wait.
    stepChk(4'd0, 4'd0, 1'b1, 6'h2b, 6'h00, 6'h2b, 1'b0, 1'b0, 1'b0, "midrst");
    stepChk(4'd1, 4'd1, 1'b0, 6'h2b, 6'h00, 6'h2b, 1'b0, 1'b0, 1'b0, "midrst");
    stepChk(4'd2, 4'd2, 1'b0, 6'h11, 6'h00, 6'h2b, 1'b0, 1'b0, 1'b0, "midrst");
    stepChk(4'd5, 4'd5, 1'b0, 6'h11, 6'h00, 6'h2b, 1'b0, 1'b0, 1'b0, "midrst");
    rstA = 1'b1; rstB = 1'b1;
    stepChk(4'd0, 4'd0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, "midrst_after");
    rstA = 1'b0; rstB = 1'b0;
    runInstr(6'h0d, 6'h00, 0, 0, "ori_after_rst");

    // Illegal opcode: A traps, B retires it as a NOP.
    stepChk(4'd0, 4'd0, 1'b1, 6'h3f, 6'h00, 6'h3f, 1'b0, 1'b0, 1'b0, "ill");
    stepChk(4'd1, 4'd1, 1'b0, 6'h3f, 6'h00, 6'h3f, 1'b0, 1'b0, 1'b1, "ill_decode");
    for (int i = 0; i < 10; i++) begin
      stepChk(4'd13, 4'd0, 1'b0, 6'($urandom), 6'($urandom), 6'h00, 1'b0, 1'b0, 1'b0, "trap_hold");
      chk("trap_illegalA", 32'(illegalA), 32'd1);
    end
    rstA = 1'b1;
    stepChk(4'd0, 4'd0, 1'b0, 6'h00, 6'h00, 6'h00, 1'b0, 1'b0, 1'b0, "trap_rst");
    rstA = 1'b0;
    chk("trap_rst_illegalA", 32'(illegalA), 32'd0);
    runInstr(6'h00, 6'h22, 0, 0, "sub_after_trap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
